// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the clk_divider_N ratio controller.
// Optional ratio ramping is selected by the CLK_DIV_CTRL_RAMP_EN macro.
package clk_div_ctrl_pkg;

  localparam int NW_DEF      = 8;
  localparam int N_RESET_DEF = 2;
  localparam int N_MIN_DEF   = 2;

  typedef logic [NW_DEF-1:0] ratio_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter mirroring the divider: counts 0..div_n-1 and flags the last
// cycle of each divided period. load0 restarts the period on a ratio switch.
module clk_div_phase_cnt
  import clk_div_ctrl_pkg::*;
#(
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] div_n,
  input  logic          load0,
  output logic [NW-1:0] cnt,
  output logic          period_tick
);

  localparam logic [NW-1:0] ONE = NW'(1);

  logic [NW-1:0] r_cnt;

  assign period_tick = (r_cnt == div_n - ONE);
  assign cnt         = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load0 || period_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio controller: accepts divide-ratio requests, rejects illegal ones and
// switches div_n only on a period boundary. Macro: CLK_DIV_CTRL_RAMP_EN (step +-1).
module clk_div_ratio_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int NW      = NW_DEF,
  parameter int N_RESET = N_RESET_DEF,
  parameter int N_MIN   = N_MIN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [NW-1:0] req_n,
  output logic          req_ready,
  output logic          req_err,
  output logic          done,
  output logic          busy,
  output logic [NW-1:0] div_n,
  output logic          period_tick
);

  localparam logic [NW-1:0] ONE     = NW'(1);
  localparam logic [NW-1:0] RESET_N = NW'(N_RESET);
  localparam logic [NW-1:0] MIN_N   = NW'(N_MIN);

  state_t        r_state, w_state_nxt;
  logic [NW-1:0] r_div_n, w_div_n_nxt;
  logic [NW-1:0] r_target, w_target_nxt;
  logic [NW-1:0] w_step;
  logic [NW-1:0] w_cnt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          w_load0, w_tick, w_accept;

  clk_div_phase_cnt #(.NW(NW)) u_phase (
    .clk         (clk),
    .rst         (rst),
    .div_n       (r_div_n),
    .load0       (w_load0),
    .cnt         (w_cnt),
    .period_tick (w_tick)
  );

  assign req_ready   = (r_state == ST_IDLE) && !rst;
  assign busy        = (r_state == ST_WAIT);
  assign done        = r_done;
  assign req_err     = r_err;
  assign div_n       = r_div_n;
  assign period_tick = w_tick;
  assign w_accept    = req_valid && req_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_div_n_nxt  = r_div_n;
    w_target_nxt = r_target;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_load0      = 1'b0;
`ifdef CLK_DIV_CTRL_RAMP_EN
    w_step = (r_target > r_div_n) ? r_div_n + ONE : r_div_n - ONE;
`else
    w_step = r_target;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_target_nxt = req_n;
          if (req_n < MIN_N) begin
            w_err_nxt = 1'b1;
          end else if (req_n == r_div_n) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Only ticks seen in WAIT count, so a tick in the accept cycle is skipped.
        if (w_tick) begin
          w_div_n_nxt = w_step;
          w_load0     = 1'b1;
          if (w_step == r_target) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // pre-edge values, independent of statement order.
    if (rst) begin
      r_state  <= ST_IDLE;
      r_div_n  <= RESET_N;
      r_target <= RESET_N;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div_n  <= w_div_n_nxt;
      r_target <= w_target_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (w_cnt < r_div_n);
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Self-checking bench for clk_div_ratio_ctrl: behavioural model compared every
// cycle, plus directed literal checks. Honours CLK_DIV_CTRL_RAMP_EN.
module tb_clk_div_ratio_ctrl;

  localparam int NW      = 8;
  localparam int N_RESET = 2;
  localparam int N_MIN   = 2;
  localparam int BUDGET  = 40000;
`ifdef CLK_DIV_CTRL_RAMP_EN
  localparam int BIG = 20;
`else
  localparam int BIG = 255;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [NW-1:0] req_n = '0;
  logic          req_ready, req_err, done, busy, period_tick;
  logic [NW-1:0] div_n;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_ratio_ctrl #(.NW(NW), .N_RESET(N_RESET), .N_MIN(N_MIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_n       (req_n),
    .req_ready   (req_ready),
    .req_err     (req_err),
    .done        (done),
    .busy        (busy),
    .div_n       (div_n),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: ratio, position within the current period, pending change.
  int m_div = N_RESET, m_cnt = 0, m_target = 0;
  bit m_pending = 0, m_done = 0, m_err = 0, m_valid = 0;

  always @(posedge clk) begin : model
    bit tick, accept;
    if (rst) begin
      m_div = N_RESET; m_cnt = 0; m_pending = 0; m_done = 0; m_err = 0; m_valid = 1;
    end else begin
      tick   = (m_cnt == m_div - 1);
      accept = !m_pending && req_valid;
      m_done = 0;
      m_err  = 0;
      m_cnt  = tick ? 0 : m_cnt + 1;
      if (m_pending && tick) begin
`ifdef CLK_DIV_CTRL_RAMP_EN
        m_div = (m_target > m_div) ? m_div + 1 : m_div - 1;
`else
        m_div = m_target;
`endif
        if (m_div == m_target) begin
          m_pending = 0;
          m_done    = 1;
        end
      end
      if (accept) begin
        if (int'(req_n) < N_MIN) m_err = 1;
        else if (int'(req_n) == m_div) m_done = 1;
        else begin
          m_pending = 1;
          m_target  = int'(req_n);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("div_n", div_n, m_div);
      check("period_tick", period_tick, (m_cnt == m_div - 1) ? 1 : 0);
      check("req_ready", req_ready, (!m_pending && !rst) ? 1 : 0);
      check("busy", busy, m_pending);
      check("done", done, m_done);
      check("req_err", req_err, m_err);
      check("err_done_excl", done && req_err, 0);
    end
  end

  task automatic send(input logic [NW-1:0] n);
    bit sent = 0;
    for (int i = 0; i < BUDGET && !sent; i++) begin
      @(posedge clk); #2;
      if (!m_pending) begin
        req_valid = 1'b1;
        req_n     = n;
        sent      = 1;
      end
    end
    check("send_accept_timeout", sent, 1);
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < BUDGET; i++) begin
      if (!m_pending) break;
      @(posedge clk); #2;
    end
    check("wait_idle_busy", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Cycle k = k-th cycle after reset release; cnt is 0 in cycle 0.
    for (int k = 0; k <= 27; k++) begin
      @(posedge clk); #2;
      rst       = 1'b0;
      req_valid = (k == 2 || k == 4 || k == 6 || k == 14 || k == 20);
      case (k)
        2:       req_n = 8'd1;
        4:       req_n = 8'd5;
        6:       req_n = 8'd4;
        default: req_n = 8'd8;
      endcase
      #2;
      case (k)
        0: begin
          check("k0_div_n", div_n, 2);
          check("k0_ready", req_ready, 1);
          check("k0_tick", period_tick, 0);
        end
        1: check("k1_tick", period_tick, 1);
        3: begin
          check("k3_err", req_err, 1);
          check("k3_div_n", div_n, 2);
          check("k3_done", done, 0);
        end
        5: begin
          check("k5_busy", busy, 1);
          check("k5_ready", req_ready, 0);
        end
        default: ;
      endcase
`ifdef CLK_DIV_CTRL_RAMP_EN
      case (k)
        6:  begin check("r6_div_n", div_n, 3); check("r6_done", done, 0); check("r6_busy", busy, 1); end
        9:  begin check("r9_div_n", div_n, 4); check("r9_done", done, 0); end
        12: begin check("r12_busy", busy, 1); check("r12_done", done, 0); end
        13: begin check("r13_div_n", div_n, 5); check("r13_done", done, 1); check("r13_busy", busy, 0); end
        default: ;
      endcase
`else
      case (k)
        6:  begin check("k6_div_n", div_n, 5); check("k6_done", done, 1); check("k6_ready", req_ready, 1); end
        9:  check("k9_tick", period_tick, 0);
        10: check("k10_tick", period_tick, 1);
        11: begin check("k11_div_n", div_n, 4); check("k11_done", done, 1); end
        14: check("k14_tick", period_tick, 1);
        18: begin check("k18_div_n", div_n, 4); check("k18_busy", busy, 1); end
        19: begin check("k19_div_n", div_n, 8); check("k19_done", done, 1); end
        21: begin check("k21_done", done, 1); check("k21_busy", busy, 0); check("k21_err", req_err, 0); end
        default: ;
      endcase
`endif
    end
    req_valid = 1'b0;

    wait_idle();
    send(NW'(BIG));
    wait_idle();
    send(8'd3);
    wait_idle();

    // Reset in the middle of a pending change must discard it silently.
    send(8'd7);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
    end
    rst = 1'b0;
    #2;
    check("post_rst_div_n", div_n, N_RESET);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_done", done, 0);
    repeat (12) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
